// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC engines.
// Angles use binary angle measure: 2^(WIDTH-1) encodes pi.
package cordic_pkg;

  localparam int unsigned CORDIC_WIDTH = 32;

  localparam logic [31:0] ANGLE_PI_2 = 32'h4000_0000;
  localparam logic [31:0] ANGLE_PI   = 32'h8000_0000;

  // 1/K in Q1.31, K being the accumulated CORDIC gain
  localparam logic [31:0] INV_GAIN   = 32'h4DBA_76D4;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StScale,
    StDone
  } cordic_state_e;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent table: atan(2^-idx) in binary angle measure, WIDTH bits.
// Stored at 32-bit precision and rounded or widened to WIDTH.
module cordic_atan_rom #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 5
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] atan_o
);

  logic [31:0] tbl;

  always_comb begin
    tbl = '0;
    case (int'(idx_i))
      0:  tbl = 32'h2000_0000;
      1:  tbl = 32'h12E4_051E;
      2:  tbl = 32'h09FB_385B;
      3:  tbl = 32'h0511_11D4;
      4:  tbl = 32'h028B_0D43;
      5:  tbl = 32'h0145_D7E1;
      6:  tbl = 32'h00A2_F61E;
      7:  tbl = 32'h0051_7C55;
      8:  tbl = 32'h0028_BE53;
      9:  tbl = 32'h0014_5F2F;
      10: tbl = 32'h000A_2F98;
      11: tbl = 32'h0005_17CC;
      12: tbl = 32'h0002_8BE6;
      13: tbl = 32'h0001_45F3;
      14: tbl = 32'h0000_A2FA;
      15: tbl = 32'h0000_517D;
      16: tbl = 32'h0000_28BE;
      17: tbl = 32'h0000_145F;
      18: tbl = 32'h0000_0A30;
      19: tbl = 32'h0000_0518;
      20: tbl = 32'h0000_028C;
      21: tbl = 32'h0000_0146;
      22: tbl = 32'h0000_00A3;
      23: tbl = 32'h0000_0051;
      24: tbl = 32'h0000_0029;
      25: tbl = 32'h0000_0014;
      26: tbl = 32'h0000_000A;
      27: tbl = 32'h0000_0005;
      28: tbl = 32'h0000_0003;
      29: tbl = 32'h0000_0001;
      30: tbl = 32'h0000_0001;
      default: tbl = '0;
    endcase
  end

  if (WIDTH == 32) begin : g_exact
    assign atan_o = tbl;
  end else if (WIDTH > 32) begin : g_wide
    assign atan_o = {tbl, {(WIDTH - 32){1'b0}}};
  end else begin : g_narrow
    // Round half-up when dropping the low bits
    logic [32:0] rnd;
    assign rnd    = {1'b0, tbl} + (33'd1 << (31 - WIDTH));
    assign atan_o = rnd[32-WIDTH +: WIDTH];
  end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring-mode CORDIC: drives y to zero, yielding magnitude and atan2.
// Define GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain from mag.
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = CORDIC_WIDTH,
  parameter int unsigned ITER  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   x_in,
  input  logic [WIDTH-1:0]   y_in,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH+1:0]   mag,
  output logic [WIDTH-1:0]   angle,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned XW = WIDTH + 2;
  localparam int unsigned IW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] PI_2 = {2'b01, {(WIDTH - 2){1'b0}}};

  cordic_state_e state_q, state_d;

  logic signed [XW-1:0] x_q, y_q;
  logic [WIDTH-1:0]     z_q;
  logic [IW-1:0]        i_q;
  logic                 zero_q;
  logic [XW-1:0]        mag_q;
  logic [WIDTH-1:0]     angle_q;

  logic signed [XW-1:0] xs, ys, x_ld, y_ld, x_rot, y_rot;
  logic [WIDTH-1:0]     z_ld, z_rot, atan_val;
  logic                 last;

  cordic_atan_rom #(
    .WIDTH (WIDTH),
    .IDX_W (IW)
  ) u_atan (
    .idx_i  (i_q),
    .atan_o (atan_val)
  );

  assign xs   = {{2{x_in[WIDTH-1]}}, x_in};
  assign ys   = {{2{y_in[WIDTH-1]}}, y_in};
  assign last = (i_q == IW'(ITER - 1));

  // Fold the left half-plane into the right so the iterations converge
  always_comb begin
    x_ld = xs;
    y_ld = ys;
    z_ld = '0;
    if (x_in[WIDTH-1]) begin
      if (!y_in[WIDTH-1]) begin
        x_ld = ys;
        y_ld = -xs;
        z_ld = PI_2;
      end else begin
        x_ld = -ys;
        y_ld = xs;
        z_ld = -PI_2;
      end
    end
  end

  always_comb begin
    if (!y_q[XW-1]) begin
      x_rot = x_q + (y_q >>> i_q);
      y_rot = y_q - (x_q >>> i_q);
      z_rot = z_q + atan_val;
    end else begin
      x_rot = x_q - (y_q >>> i_q);
      y_rot = y_q + (x_q >>> i_q);
      z_rot = z_q - atan_val;
    end
  end

`ifdef GAIN_COMP_EN
  logic signed [XW+32:0] prod;
  assign prod = x_q * $signed({1'b0, INV_GAIN});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StIter;
`ifdef GAIN_COMP_EN
      StIter:  if (last) state_d = StScale;
      StScale: state_d = StDone;
`else
      StIter:  if (last) state_d = StDone;
      StScale: state_d = StIdle;
`endif
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q    <= x_ld;
            y_q    <= y_ld;
            z_q    <= z_ld;
            i_q    <= '0;
            zero_q <= (x_in == '0) && (y_in == '0);
          end
        end
        StIter: begin
          x_q <= x_rot;
          y_q <= y_rot;
          z_q <= z_rot;
          i_q <= i_q + IW'(1);
`ifndef GAIN_COMP_EN
          if (last) begin
            mag_q   <= zero_q ? '0 : x_rot;
            angle_q <= zero_q ? '0 : z_rot;
          end
`endif
        end
`ifdef GAIN_COMP_EN
        StScale: begin
          mag_q   <= zero_q ? '0 : prod[XW+30:31];
          angle_q <= zero_q ? '0 : z_q;
        end
`endif
        default: ;
      endcase
    end
  end

  assign mag   = mag_q;
  assign angle = angle_q;

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// Directed checks for cordic_vectoring_iter: quadrants, zero input, handshake, reset.
// Expected magnitudes follow GAIN_COMP_EN when it is defined.
module tb_cordic_vectoring_iter;

`ifdef GAIN_COMP_EN
  localparam bit GAIN = 1'b1;
  localparam int LAT  = 17;
`else
  localparam bit GAIN = 1'b0;
  localparam int LAT  = 16;
`endif

  localparam longint MAG_1   = GAIN ? 64'd268435456  : 64'd442048872;
  localparam longint MAG_2   = GAIN ? 64'd379625062  : 64'd625151522;
  localparam longint MAG_MIN = GAIN ? 64'd2147483648 : 64'd3536390728;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] x_in, y_in;
  logic        in_valid, in_ready;
  logic [33:0] mag;
  logic [31:0] angle;
  logic        out_valid, out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_vectoring_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_in      (x_in),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag       (mag),
    .angle     (angle),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input longint obs, input longint exp,
                           input longint tol, input bit wrap);
    longint     d;
    logic [63:0] dv;
    n_checks++;
    d = obs - exp;
    if (wrap) begin
      dv = d;
      d  = longint'($signed(dv[31:0]));
    end
    if (d < 0) d = -d;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Presents one sample, then optionally keeps in_valid high with junk while busy
  task automatic run_sample(input logic [31:0] x, input logic [31:0] y, input bit junk,
                            output int lat);
    int n;
    @(negedge clk);
    x_in = x;
    y_in = y;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    if (junk) begin
      x_in = 32'hA5A5_0000;
      y_in = 32'h1234_5678;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_val({tag, "_idle"}, longint'(in_ready), 1, 0, 1'b0);
  endtask

  task automatic vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                     input longint emag, input longint mtol, input longint eang,
                     input longint atol);
    int lat;
    run_sample(x, y, 1'b0, lat);
    check_val({tag, "_lat"}, lat, LAT, 0, 1'b0);
    check_val({tag, "_mag"}, longint'(mag), emag, mtol, 1'b0);
    check_val({tag, "_ang"}, longint'(angle), eang, atol, 1'b1);
    release_out(tag);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    x_in      = '0;
    y_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    check_val("rst_in_ready", longint'(in_ready), 1, 0, 1'b0);
    check_val("rst_out_valid", longint'(out_valid), 0, 0, 1'b0);
    check_val("rst_mag", longint'(mag), 0, 0, 1'b0);
    check_val("rst_angle", longint'(angle), 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    vec("pos_x", 32'h1000_0000, 32'h0, MAG_1, 64, 0, 32768);
    vec("diag", 32'h1000_0000, 32'h1000_0000, MAG_2, 64, 64'h2000_0000, 32768);
    vec("neg_x", 32'hF000_0000, 32'h0, MAG_1, 64, 64'h8000_0000, 32768);
    vec("neg_y", 32'h0, 32'hF000_0000, MAG_1, 64, 64'hC000_0000, 32768);
    vec("zero", 32'h0, 32'h0, 0, 0, 0, 0);
    vec("min_x", 32'h8000_0000, 32'h0, MAG_MIN, 256, 64'h8000_0000, 32768);

    // Backpressure with in_valid asserted throughout the busy period
    run_sample(32'h1000_0000, 32'h1000_0000, 1'b1, lat);
    check_val("bp_lat", lat, LAT, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_val("bp_valid", longint'(out_valid), 1, 0, 1'b0);
    check_val("bp_in_ready", longint'(in_ready), 0, 0, 1'b0);
    check_val("bp_mag", longint'(mag), MAG_2, 64, 1'b0);
    check_val("bp_ang", longint'(angle), 64'h2000_0000, 32768, 1'b1);
    release_out("bp");
    check_val("bp_valid_drop", longint'(out_valid), 0, 0, 1'b0);

    // Reset during iteration 7
    @(negedge clk);
    x_in = 32'h1000_0000;
    y_in = 32'h0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", longint'(out_valid), 0, 0, 1'b0);
    check_val("mid_rst_in_ready", longint'(in_ready), 1, 0, 1'b0);
    check_val("mid_rst_mag", longint'(mag), 0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    vec("post_rst", 32'hF000_0000, 32'h1000_0000, MAG_2, 64, 64'h6000_0000, 32768);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit %0d ns", 200000);
    $fatal(1, "watchdog");
  end

endmodule
